beam_steer_scheduler: RTL
=========================

Name: beam_steer_scheduler

Overview:
- Sequences the 16-channel delay-and-sum datapath of the beamformer, one output sample per frame.
- On each sample tick it snapshots the per-channel steering delays and walks channels 0..15, issuing one read per cycle to the shared delay-line memory.
- It accumulates the returned samples and emits one beam sample with a valid pulse.
- Sits between the mic delay lines and the output serializer; steering delays are loaded through a simple config write port.

Parameters:
- NUM_CH, 16, number of microphone channels (power of two; channel index width CH_W = log2(NUM_CH)).
- SAMPLE_W, 8, signed sample width returned by the delay lines.
- DELAY_W, 5, steering delay width in samples (0..31).
- ACC_W, SAMPLE_W+4, signed accumulator/output width; sized so a full-scale sum of NUM_CH samples cannot overflow.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- sample_tick  input  1  frame start request, one-cycle pulse.
- cfg_we  input  1  write strobe for the shadow delay table.
- cfg_addr  input  CH_W  channel being written.
- cfg_data  input  DELAY_W  delay value to write.
- rd_en  output  1  read request to the delay-line memory.
- rd_ch  output  CH_W  channel index of the read.
- rd_delay  output  DELAY_W  delay tap for the read.
- rd_data  input  SAMPLE_W  signed sample; valid exactly 1 cycle after rd_en.
- sum_out  output  ACC_W  signed beam sample; held until the next frame completes.
- sum_valid  output  1  one-cycle pulse when sum_out updates.
- busy  output  1  high from the cycle after an accepted tick through the DONE cycle.
- overrun  output  1  sticky; set when a tick is dropped.

Behaviour:
- Reset values: all outputs 0, both delay tables 0, accumulator 0, state IDLE.
- FSM states and transitions:
  - IDLE: sample_tick=1 moves to ISSUE. On the same edge: active table <= shadow table (pre-write contents if cfg_we coincides), channel counter <= 0, accumulator <= 0.
  - ISSUE: rd_en=1, rd_ch=counter, rd_delay=active[counter]; counter increments each cycle; leaves for DRAIN after counter = NUM_CH-1.
  - DRAIN: rd_en=0; one cycle to accept the final rd_data.
  - DONE: sum_out <= accumulator, sum_valid=1 for this cycle only, then IDLE.
- Cycle timing (tick sampled in cycle 0):
  - ISSUE occupies cycles 1..NUM_CH.
  - rd_data for channel k arrives in cycle k+2.
  - sum_valid=1 in cycle NUM_CH+2 (18 at default).
- Accumulation: in every cycle where registered rd_en is high, accumulator += sign-extended rd_data. No saturation is needed; ACC_W guarantees range (-2048..2032 at default).
- Config writes:
  - cfg_we writes shadow[cfg_addr] <= cfg_data in any state.
  - The active table changes only at tick acceptance, so the frame in progress always uses the delays snapshotted at its start.
- Back-to-back frames: a tick is accepted only in IDLE. The earliest tick that is accepted falls in the cycle after DONE.
- Tick while busy (ISSUE/DRAIN/DONE): ignored, overrun <= 1; only rst clears overrun.
- Reset mid-frame: abort immediately. No sum_valid is produced, and sum_out, busy and rd_en return to 0 the next cycle.

Optional Feature:
- Macro CHAN_MASK_EN.
- When defined:
  - Adds input ports cfg_mask_we (1) and cfg_mask (NUM_CH); cfg_mask_we loads a shadow mask, reset value all ones.
  - The mask is snapshotted with the delay table.
  - In ISSUE a masked-off channel keeps its cycle slot (latency unchanged), drives rd_en=0 and contributes 0.
- When undefined: these ports are absent and all channels are always summed.

Test Plan:
1. Reset; delays all 0; tick; rd_data held at 5 -> rd_ch steps 0..15 in cycles 1..16, rd_delay all 0, sum_valid in cycle 18 with sum_out=80, busy low in cycle 19.
2. Write delay[k]=k for all k, then tick -> rd_delay equals rd_ch on every ISSUE cycle.
3. rd_data=-128 on all channels -> sum_out=-2048; rd_data=+127 on all channels -> sum_out=2032.
4. Second tick in cycle 5 of a frame -> no restart, exactly one sum_valid, overrun=1, still 1 after a later frame.
5. Write delay[3]=7 in cycle 4 of a frame -> current frame rd_delay for ch3 = old value 0; next frame = 7.
6. rst asserted in cycle 10 -> busy=0 and rd_en=0 next cycle, no sum_valid. With CHAN_MASK_EN: mask=0x00FF, rd_data=1 -> sum_out=8, rd_en low for ch8..15.

Source files
------------

// File: rtl/beam_steer_scheduler.sv
// Delay-and-sum frame scheduler: snapshots steering delays per tick, issues one
// delay-line read per channel and accumulates one beam sample. Optional: CHAN_MASK_EN.
module beam_steer_scheduler #(
  parameter int NUM_CH   = 16,
  parameter int SAMPLE_W = 8,
  parameter int DELAY_W  = 5,
  parameter int ACC_W    = SAMPLE_W + 4,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_addr,
  input  logic [DELAY_W-1:0]  cfg_data,
`ifdef CHAN_MASK_EN
  input  logic                cfg_mask_we,
  input  logic [NUM_CH-1:0]   cfg_mask,
`endif
  output logic                rd_en,
  output logic [CH_W-1:0]     rd_ch,
  output logic [DELAY_W-1:0]  rd_delay,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic [ACC_W-1:0]    sum_out,
  output logic                sum_valid,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    sum_q, sum_d;
  logic                       overrun_q, overrun_d;
  logic                       rd_en_q;
  logic [DELAY_W-1:0]         shadow_q [NUM_CH];
  logic [DELAY_W-1:0]         active_q [NUM_CH];
  logic                       tick_accept;
  logic                       chan_on;
  logic signed [ACC_W-1:0]    rd_data_ext;

  assign tick_accept = (state_q == IDLE) && sample_tick;
  assign rd_data_ext = {{(ACC_W-SAMPLE_W){rd_data[SAMPLE_W-1]}}, rd_data};

`ifdef CHAN_MASK_EN
  logic [NUM_CH-1:0] shadow_mask_q;
  logic [NUM_CH-1:0] active_mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_mask_q <= '1;
      active_mask_q <= '1;
    end else begin
      if (cfg_mask_we) shadow_mask_q <= cfg_mask;
      if (tick_accept) active_mask_q <= shadow_mask_q;
    end
  end

  assign chan_on = active_mask_q[cnt_q];
`else
  assign chan_on = 1'b1;
`endif

  // Shadow table takes writes at any time; the active copy only moves at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (tick_accept) begin
        for (int i = 0; i < NUM_CH; i++) active_q[i] <= shadow_q[i];
      end
      if (cfg_we) shadow_q[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      overrun_q <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      overrun_q <= overrun_d;
      rd_en_q   <= rd_en;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    overrun_d = overrun_q;
    rd_en     = 1'b0;
    rd_ch     = '0;
    rd_delay  = '0;
    sum_valid = 1'b0;
    sum_out   = sum_q;
    busy      = (state_q != IDLE);

    // Read data lags the request by one cycle, so the registered strobe qualifies it.
    if (rd_en_q) acc_d = acc_q + rd_data_ext;

    if ((state_q != IDLE) && sample_tick) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = ISSUE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ISSUE: begin
        rd_en    = chan_on;
        rd_ch    = cnt_q;
        rd_delay = active_q[cnt_q];
        cnt_d    = cnt_q + CH_W'(1);
        if (cnt_q == CH_W'(NUM_CH - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        sum_valid = 1'b1;
        sum_out   = acc_q;
        sum_d     = acc_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign overrun = overrun_q;

endmodule
